// File: rtl/ddr2_sdram_bridge_pkg.sv
// Shared types and address-field defaults for the DDR2 Avalon-to-local bridge.
package ddr2_sdram_bridge_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        WBURST = 2'd2
    } bridge_state_t;

    localparam int DEF_ROW_W  = 13;
    localparam int DEF_BANK_W = 2;
    localparam int DEF_COL_W  = 9;

    // Bank field sits directly above the column field; row sits above the bank.
    function automatic int bank_lsb(input int col_w);
        return col_w;
    endfunction

endpackage

// File: rtl/ddr2_sdram_bridge_pend_cnt.sv
// Outstanding read-beat counter: adds a burst on read accept, removes one beat per returned word.
module ddr2_sdram_bridge_pend_cnt #(
    parameter int MAX_PEND = 8,
    parameter int AMT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [AMT_W-1:0] amt,
    input  logic             dec,
    output logic             can_accept
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam int SUM_W = CNT_W + AMT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic [SUM_W-1:0] cnt_ext;
    logic [SUM_W-1:0] amt_ext;
    logic [SUM_W-1:0] cnt_nxt;

    assign cnt_ext    = SUM_W'(cnt);
    assign amt_ext    = SUM_W'(amt);
    assign can_accept = (cnt_ext + amt_ext) <= SUM_W'(MAX_PEND);

    // Returns arriving with nothing pending (data in flight across a reset) are absorbed at 0.
    always_comb begin
        cnt_nxt = cnt_ext;
        if (inc) begin
            cnt_nxt = cnt_nxt + amt_ext;
        end
        if (dec && (cnt_nxt != '0)) begin
            cnt_nxt = cnt_nxt - SUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            cnt <= CNT_W'(cnt_nxt);
            if (inc) begin
                armed <= 1'b1;
            end
        end
    end

    // Once a read has been issued since reset, a return with nothing pending is a protocol error.
    assert property (@(posedge clk) disable iff (reset) !(dec && !inc && armed && (cnt == '0)));
    assert property (@(posedge clk) disable iff (reset) cnt <= CNT_W'(MAX_PEND));

endmodule

// File: rtl/ddr2_sdram_avalon_local_bridge.sv
// Avalon-MM burst slave to DDR2 HP controller local-interface bridge.
// Optional DDR2_BRIDGE_PERF_CNT_EN adds read/write beat performance counters.
module ddr2_sdram_avalon_local_bridge
    import ddr2_sdram_bridge_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 24,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int BANK_W   = DEF_BANK_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int BURST_W  = 2,
    parameter int MAX_PEND = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   avl_address,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [BURST_W-1:0]  avl_burstcount,
    input  logic                avl_beginbursttransfer,
    input  logic [DATA_W-1:0]   avl_writedata,
    input  logic [DATA_W/8-1:0] avl_byteenable,
    output logic                avl_waitrequest,
    output logic [DATA_W-1:0]   avl_readdata,
    output logic                avl_readdatavalid,
    input  logic                local_ready,
    input  logic                local_init_done,
    input  logic [DATA_W-1:0]   local_rdata,
    input  logic                local_rdata_valid,
    output logic                local_read_req,
    output logic                local_write_req,
    output logic                local_burstbegin,
    output logic [BURST_W-1:0]  local_size,
    output logic                local_cs_addr,
    output logic [ROW_W-1:0]    local_row_addr,
    output logic [BANK_W-1:0]   local_bank_addr,
    output logic [COL_W-1:0]    local_col_addr,
    output logic [DATA_W-1:0]   local_wdata,
    output logic [DATA_W/8-1:0] local_be
`ifdef DDR2_BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0]         perf_rd_beats,
    output logic [31:0]         perf_wr_beats
`endif
);

    localparam int BANK_LSB = bank_lsb(COL_W);

    bridge_state_t      state, state_nxt;
    logic [BURST_W-1:0] wbeat_cnt, wbeat_nxt;
    logic [BURST_W-1:0] eff_burst;
    logic               can_accept;
    logic               rd_block;
    logic               acc_wr;
    logic               acc_rd;
    logic               cmd_v;
    logic               cmd_rd;
    logic               cmd_wr;
    logic               cmd_bb;

    assign eff_burst = (avl_burstcount == '0) ? BURST_W'(1) : avl_burstcount;

    // Reads stall inside a write burst and when the return path could overfill.
    assign rd_block        = avl_read & (!can_accept | (state == WBURST));
    assign avl_waitrequest = reset | (state == INIT) | (cmd_v & !local_ready) | rd_block;

    // Write takes priority; a simultaneous read is simply not accepted.
    assign acc_wr = avl_write & !avl_waitrequest;
    assign acc_rd = avl_read & !avl_write & !avl_waitrequest;

    ddr2_sdram_bridge_pend_cnt #(
        .MAX_PEND (MAX_PEND),
        .AMT_W    (BURST_W)
    ) u_pend (
        .clk        (clk),
        .reset      (reset),
        .inc        (acc_rd),
        .amt        (eff_burst),
        .dec        (local_rdata_valid),
        .can_accept (can_accept)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            wbeat_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wbeat_cnt <= wbeat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wbeat_nxt = wbeat_cnt;
        case (state)
            INIT: begin
                if (local_init_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (acc_wr && (eff_burst > BURST_W'(1))) begin
                    state_nxt = WBURST;
                    wbeat_nxt = eff_burst - BURST_W'(1);
                end
            end
            WBURST: begin
                if (acc_wr) begin
                    wbeat_nxt = wbeat_cnt - BURST_W'(1);
                    if (wbeat_cnt == BURST_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_v           <= 1'b0;
            cmd_rd          <= 1'b0;
            cmd_wr          <= 1'b0;
            cmd_bb          <= 1'b0;
            local_size      <= '0;
            local_row_addr  <= '0;
            local_bank_addr <= '0;
            local_col_addr  <= '0;
            local_wdata     <= '0;
            local_be        <= '0;
        end else if (acc_wr || acc_rd) begin
            cmd_v       <= 1'b1;
            cmd_rd      <= acc_rd;
            cmd_wr      <= acc_wr;
            cmd_bb      <= acc_rd | (state == RUN);
            local_wdata <= avl_writedata;
            local_be    <= avl_byteenable;
            // Later write beats keep the address and size of the first beat.
            if (state != WBURST) begin
                local_size      <= eff_burst;
                local_row_addr  <= avl_address[ADDR_W-1 -: ROW_W];
                local_bank_addr <= avl_address[BANK_LSB +: BANK_W];
                local_col_addr  <= avl_address[COL_W-1:0];
            end
        end else if (cmd_v && local_ready) begin
            cmd_v <= 1'b0;
        end
    end

    assign local_read_req   = cmd_v & cmd_rd;
    assign local_write_req  = cmd_v & cmd_wr;
    assign local_burstbegin = cmd_v & cmd_bb;
    assign local_cs_addr    = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            avl_readdata      <= '0;
            avl_readdatavalid <= 1'b0;
        end else begin
            avl_readdata      <= local_rdata;
            avl_readdatavalid <= local_rdata_valid;
        end
    end

`ifdef DDR2_BRIDGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_beats <= '0;
            perf_wr_beats <= '0;
        end else begin
            if (avl_readdatavalid) begin
                perf_rd_beats <= perf_rd_beats + 32'd1;
            end
            if (acc_wr) begin
                perf_wr_beats <= perf_wr_beats + 32'd1;
            end
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = avl_beginbursttransfer;

endmodule

// File: tb/tb_ddr2_sdram_avalon_local_bridge.sv
// Directed self-checking bench for the DDR2 Avalon-to-local bridge.
module tb_ddr2_sdram_avalon_local_bridge;
    import ddr2_sdram_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [1:0]  avl_burstcount;
    logic        avl_beginbursttransfer;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic        local_ready;
    logic        local_init_done;
    logic [31:0] local_rdata;
    logic        local_rdata_valid;
    logic        local_read_req;
    logic        local_write_req;
    logic        local_burstbegin;
    logic [1:0]  local_size;
    logic        local_cs_addr;
    logic [12:0] local_row_addr;
    logic [1:0]  local_bank_addr;
    logic [8:0]  local_col_addr;
    logic [31:0] local_wdata;
    logic [3:0]  local_be;
`ifdef DDR2_BRIDGE_PERF_CNT_EN
    logic [31:0] perf_rd_beats;
    logic [31:0] perf_wr_beats;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr2_sdram_avalon_local_bridge dut (
        .clk                    (clk),
        .reset                  (reset),
        .avl_address            (avl_address),
        .avl_read               (avl_read),
        .avl_write              (avl_write),
        .avl_burstcount         (avl_burstcount),
        .avl_beginbursttransfer (avl_beginbursttransfer),
        .avl_writedata          (avl_writedata),
        .avl_byteenable         (avl_byteenable),
        .avl_waitrequest        (avl_waitrequest),
        .avl_readdata           (avl_readdata),
        .avl_readdatavalid      (avl_readdatavalid),
        .local_ready            (local_ready),
        .local_init_done        (local_init_done),
        .local_rdata            (local_rdata),
        .local_rdata_valid      (local_rdata_valid),
        .local_read_req         (local_read_req),
        .local_write_req        (local_write_req),
        .local_burstbegin       (local_burstbegin),
        .local_size             (local_size),
        .local_cs_addr          (local_cs_addr),
        .local_row_addr         (local_row_addr),
        .local_bank_addr        (local_bank_addr),
        .local_col_addr         (local_col_addr),
        .local_wdata            (local_wdata),
        .local_be               (local_be)
`ifdef DDR2_BRIDGE_PERF_CNT_EN
        ,
        .perf_rd_beats          (perf_rd_beats),
        .perf_wr_beats          (perf_wr_beats)
`endif
    );

    // Presents one command right after a negedge and returns at the negedge after acceptance.
    task automatic drive_cmd(input logic rd, input logic wr, input logic [23:0] addr,
                             input logic [1:0] bc, input logic [31:0] d, output bit ok);
        avl_read       = rd;
        avl_write      = wr;
        avl_address    = addr;
        avl_burstcount = bc;
        avl_writedata  = d;
        avl_byteenable = 4'hF;
        avl_beginbursttransfer = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!avl_waitrequest) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        avl_read  = 1'b0;
        avl_write = 1'b0;
        avl_beginbursttransfer = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (avl_waitrequest !== 1'b1 || avl_readdatavalid !== 1'b0 || avl_readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_avl: waitrequest=%b rdv=%b rdata=%h, required 1 0 0",
                     avl_waitrequest, avl_readdatavalid, avl_readdata);
        end
        total++;
        if ({local_read_req, local_write_req, local_burstbegin, local_cs_addr} !== 4'b0 ||
            local_size !== 2'd0 || local_row_addr !== 13'd0 || local_bank_addr !== 2'd0 ||
            local_col_addr !== 9'd0 || local_wdata !== 32'd0 || local_be !== 4'd0) begin
            bad++;
            $display("FAIL reset_local: rd=%b wr=%b bb=%b size=%0d row=%h wdata=%h, required all 0",
                     local_read_req, local_write_req, local_burstbegin, local_size,
                     local_row_addr, local_wdata);
        end
        total++;
        if (dut.state !== INIT || dut.wbeat_cnt !== 2'd0 || dut.u_pend.cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d wbeat=%0d pend=%0d, required 0 0 0",
                     dut.state, dut.wbeat_cnt, dut.u_pend.cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_init_gating;
        local_ready    = 1'b1;
        avl_write      = 1'b1;
        avl_address    = 24'h000040;
        avl_burstcount = 2'd0;
        avl_writedata  = 32'hA5A5A5A5;
        avl_byteenable = 4'h3;
        for (int i = 0; i < 20; i++) begin
            #1;
            total++;
            if (avl_waitrequest !== 1'b1 || local_write_req !== 1'b0) begin
                bad++;
                $display("FAIL init_hold cyc %0d: waitrequest=%b write_req=%b, required 1 0",
                         i, avl_waitrequest, local_write_req);
            end
            @(negedge clk);
        end
        local_init_done = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (avl_waitrequest !== 1'b0 || dut.state !== RUN) begin
            bad++;
            $display("FAIL init_release: waitrequest=%b state=%0d, required 0 RUN",
                     avl_waitrequest, dut.state);
        end
        @(negedge clk);
        avl_write = 1'b0;
        total++;
        if (local_write_req !== 1'b1 || local_size !== 2'd1 || local_wdata !== 32'hA5A5A5A5 ||
            local_be !== 4'h3 || local_col_addr !== 9'h040 || local_burstbegin !== 1'b1) begin
            bad++;
            $display("FAIL init_write: wr=%b size=%0d wdata=%h be=%h col=%h bb=%b, required 1 1 a5a5a5a5 3 040 1",
                     local_write_req, local_size, local_wdata, local_be, local_col_addr, local_burstbegin);
        end
        @(negedge clk);
        total++;
        if (local_write_req !== 1'b0) begin
            bad++;
            $display("FAIL init_write_clear: write_req=%b, required 0", local_write_req);
        end
    endtask

    task automatic test_address_split;
        bit ok;
        drive_cmd(1'b1, 1'b0, 24'hABCDEF, 2'd1, 32'h0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL addr_accept: timeout waiting for waitrequest low");
        end
        total++;
        if (local_read_req !== 1'b1 || local_row_addr !== 13'h1579 || local_bank_addr !== 2'b10 ||
            local_col_addr !== 9'h1EF || local_size !== 2'd1 || local_burstbegin !== 1'b1) begin
            bad++;
            $display("FAIL addr_split: rd=%b row=%h bank=%b col=%h size=%0d bb=%b, required 1 1579 10 1ef 1 1",
                     local_read_req, local_row_addr, local_bank_addr, local_col_addr,
                     local_size, local_burstbegin);
        end
        total++;
        if (dut.u_pend.cnt !== 4'd1) begin
            bad++;
            $display("FAIL addr_pend: pend=%0d, required 1", dut.u_pend.cnt);
        end
        local_rdata_valid = 1'b1;
        local_rdata       = 32'hCAFEF00D;
        @(negedge clk);
        local_rdata_valid = 1'b0;
        total++;
        if (avl_readdatavalid !== 1'b1 || avl_readdata !== 32'hCAFEF00D || local_read_req !== 1'b0) begin
            bad++;
            $display("FAIL addr_return: rdv=%b rdata=%h rd=%b, required 1 cafef00d 0",
                     avl_readdatavalid, avl_readdata, local_read_req);
        end
        @(negedge clk);
        total++;
        if (avl_readdatavalid !== 1'b0 || dut.u_pend.cnt !== 4'd0) begin
            bad++;
            $display("FAIL addr_return_end: rdv=%b pend=%0d, required 0 0",
                     avl_readdatavalid, dut.u_pend.cnt);
        end
    endtask

    task automatic test_write_burst;
        bit ok;
        local_ready = 1'b0;
        drive_cmd(1'b0, 1'b1, 24'h000100, 2'd2, 32'h11111111, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wburst_beat1_accept: timeout");
        end
        total++;
        if (local_write_req !== 1'b1 || local_burstbegin !== 1'b1 || local_col_addr !== 9'h100 ||
            local_row_addr !== 13'h0 || local_size !== 2'd2 || local_wdata !== 32'h11111111 ||
            dut.state !== WBURST) begin
            bad++;
            $display("FAIL wburst_beat1: wr=%b bb=%b col=%h size=%0d wdata=%h state=%0d, required 1 1 100 2 11111111 WBURST",
                     local_write_req, local_burstbegin, local_col_addr, local_size, local_wdata, dut.state);
        end
        avl_write      = 1'b1;
        avl_address    = 24'h7FFFFF;
        avl_burstcount = 2'd0;
        avl_writedata  = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (avl_waitrequest !== 1'b1 || local_write_req !== 1'b1 || local_wdata !== 32'h11111111) begin
                bad++;
                $display("FAIL wburst_stall cyc %0d: waitrequest=%b wr=%b wdata=%h, required 1 1 11111111",
                         i, avl_waitrequest, local_write_req, local_wdata);
            end
            @(negedge clk);
        end
        local_ready = 1'b1;
        #1;
        total++;
        if (avl_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL wburst_release: waitrequest=%b, required 0", avl_waitrequest);
        end
        @(negedge clk);
        avl_write = 1'b0;
        total++;
        if (local_write_req !== 1'b1 || local_burstbegin !== 1'b0 || local_col_addr !== 9'h100 ||
            local_row_addr !== 13'h0 || local_bank_addr !== 2'd0 || local_size !== 2'd2 ||
            local_wdata !== 32'h22222222 || dut.state !== RUN) begin
            bad++;
            $display("FAIL wburst_beat2: wr=%b bb=%b col=%h row=%h size=%0d wdata=%h state=%0d, required 1 0 100 0 2 22222222 RUN",
                     local_write_req, local_burstbegin, local_col_addr, local_row_addr,
                     local_size, local_wdata, dut.state);
        end
        @(negedge clk);
        total++;
        if (local_write_req !== 1'b0) begin
            bad++;
            $display("FAIL wburst_clear: write_req=%b, required 0", local_write_req);
        end
    endtask

    task automatic test_read_throttle;
        bit ok;
        local_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b1, 1'b0, 24'h001000 + 24'(i * 2), 2'd2, 32'h0, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL throttle_read%0d: timeout", i);
            end
        end
        total++;
        if (dut.u_pend.cnt !== 4'd8) begin
            bad++;
            $display("FAIL throttle_pend8: pend=%0d, required 8", dut.u_pend.cnt);
        end
        avl_read       = 1'b1;
        avl_address    = 24'h002000;
        avl_burstcount = 2'd2;
        #1;
        total++;
        if (avl_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL throttle_stall_full: waitrequest=%b, required 1", avl_waitrequest);
        end
        @(negedge clk);
        local_rdata_valid = 1'b1;
        local_rdata       = 32'h0000AAAA;
        @(negedge clk);
        local_rdata_valid = 1'b0;
        #1;
        total++;
        if (avl_waitrequest !== 1'b1 || dut.u_pend.cnt !== 4'd7) begin
            bad++;
            $display("FAIL throttle_stall_7: waitrequest=%b pend=%0d, required 1 7",
                     avl_waitrequest, dut.u_pend.cnt);
        end
        @(negedge clk);
        local_rdata_valid = 1'b1;
        local_rdata       = 32'h0000BBBB;
        @(negedge clk);
        local_rdata_valid = 1'b0;
        #1;
        total++;
        if (avl_waitrequest !== 1'b0 || dut.u_pend.cnt !== 4'd6 || avl_readdata !== 32'h0000BBBB) begin
            bad++;
            $display("FAIL throttle_open_6: waitrequest=%b pend=%0d rdata=%h, required 0 6 0000bbbb",
                     avl_waitrequest, dut.u_pend.cnt, avl_readdata);
        end
        @(negedge clk);
        avl_read = 1'b0;
        total++;
        if (local_read_req !== 1'b1 || dut.u_pend.cnt !== 4'd8 || local_row_addr !== 13'h0004) begin
            bad++;
            $display("FAIL throttle_fifth: rd=%b pend=%0d row=%h, required 1 8 0004",
                     local_read_req, dut.u_pend.cnt, local_row_addr);
        end
        for (int i = 0; i < 8; i++) begin
            local_rdata_valid = 1'b1;
            local_rdata       = 32'h100 + 32'(i);
            @(negedge clk);
            total++;
            if (avl_readdatavalid !== 1'b1 || avl_readdata !== 32'h100 + 32'(i)) begin
                bad++;
                $display("FAIL throttle_drain beat %0d: rdv=%b rdata=%h, required 1 %h",
                         i, avl_readdatavalid, avl_readdata, 32'h100 + 32'(i));
            end
        end
        local_rdata_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.u_pend.cnt !== 4'd0 || avl_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL throttle_drained: pend=%0d rdv=%b, required 0 0",
                     dut.u_pend.cnt, avl_readdatavalid);
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        drive_cmd(1'b1, 1'b0, 24'h003000, 2'd3, 32'h0, ok);
        total++;
        if (!ok || dut.u_pend.cnt !== 4'd3 || local_size !== 2'd3) begin
            bad++;
            $display("FAIL simul_setup: ok=%0d pend=%0d size=%0d, required 1 3 3",
                     ok, dut.u_pend.cnt, local_size);
        end
        local_rdata_valid = 1'b1;
        local_rdata       = 32'h00000005;
        drive_cmd(1'b1, 1'b0, 24'h003100, 2'd2, 32'h0, ok);
        local_rdata_valid = 1'b0;
        total++;
        if (!ok || dut.u_pend.cnt !== 4'd4) begin
            bad++;
            $display("FAIL simul_net: ok=%0d pend=%0d, required 1 4", ok, dut.u_pend.cnt);
        end
        total++;
        if (avl_readdatavalid !== 1'b1 || avl_readdata !== 32'h00000005) begin
            bad++;
            $display("FAIL simul_rdv: rdv=%b rdata=%h, required 1 00000005",
                     avl_readdatavalid, avl_readdata);
        end
        @(negedge clk);
        total++;
        if (avl_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL simul_rdv_end: rdv=%b, required 0", avl_readdatavalid);
        end
        local_rdata_valid = 1'b1;
        repeat (4) @(negedge clk);
        local_rdata_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.u_pend.cnt !== 4'd0) begin
            bad++;
            $display("FAIL simul_drained: pend=%0d, required 0", dut.u_pend.cnt);
        end
    endtask

    task automatic test_write_wins;
        bit ok;
        drive_cmd(1'b1, 1'b1, 24'h000200, 2'd1, 32'h33333333, ok);
        total++;
        if (!ok || local_write_req !== 1'b1 || local_read_req !== 1'b0 ||
            local_wdata !== 32'h33333333 || dut.u_pend.cnt !== 4'd0) begin
            bad++;
            $display("FAIL write_wins: ok=%0d wr=%b rd=%b wdata=%h pend=%0d, required 1 1 0 33333333 0",
                     ok, local_write_req, local_read_req, local_wdata, dut.u_pend.cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        drive_cmd(1'b0, 1'b1, 24'h0A0100, 2'd2, 32'h44444444, ok);
        total++;
        if (!ok || dut.state !== WBURST || dut.wbeat_cnt !== 2'd1) begin
            bad++;
            $display("FAIL rstmid_setup: ok=%0d state=%0d wbeat=%0d, required 1 WBURST 1",
                     ok, dut.state, dut.wbeat_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({local_read_req, local_write_req, local_burstbegin, local_cs_addr} !== 4'b0 ||
            local_size !== 2'd0 || local_row_addr !== 13'd0 || local_bank_addr !== 2'd0 ||
            local_col_addr !== 9'd0 || local_wdata !== 32'd0 || local_be !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_local: wr=%b bb=%b size=%0d row=%h col=%h wdata=%h, required all 0",
                     local_write_req, local_burstbegin, local_size, local_row_addr,
                     local_col_addr, local_wdata);
        end
        total++;
        if (dut.state !== INIT || avl_waitrequest !== 1'b1 || dut.wbeat_cnt !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_state: state=%0d waitrequest=%b wbeat=%0d, required INIT 1 0",
                     dut.state, avl_waitrequest, dut.wbeat_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b1;
        avl_address            = '0;
        avl_read               = 1'b0;
        avl_write              = 1'b0;
        avl_burstcount         = '0;
        avl_beginbursttransfer = 1'b0;
        avl_writedata          = '0;
        avl_byteenable         = '0;
        local_ready            = 1'b0;
        local_init_done        = 1'b0;
        local_rdata            = '0;
        local_rdata_valid      = 1'b0;

        test_reset;
        test_init_gating;
        test_address_split;
        test_write_burst;
        test_read_throttle;
        test_simultaneous;
        test_write_wins;
        test_reset_mid_burst;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
